// File: rtl/bus_request_ctrl_if.sv
// Signal bundle between bus_request_ctrl and its software, UART TX/RX and checksum neighbours.
// Strobes: enable, done_rx and enable_tx are single-cycle pulses; data_rx is valid only while done_rx=1.
interface bus_request_ctrl_if #(
    parameter int NBYTES = 2
);
    logic                  enable;
    logic [7:0]            cmd;
    logic [7:0]            data_rx;
    logic                  done_rx;
    logic                  active_tx;
    logic                  done_tx;
    logic                  result_checksum;
    logic [7:0]            tx_byte;
    logic                  enable_tx;
    logic [8*NBYTES-1:0]   data;
    logic [7:0]            crc;
    logic [2:0]            status;
    logic [1:0]            retry_count;
    logic                  busy;
    logic [2:0]            dbg_state;

    modport slave (
        input  enable, cmd, data_rx, done_rx, active_tx, done_tx, result_checksum,
        output tx_byte, enable_tx, data, crc, status, retry_count, busy, dbg_state
    );

    modport master (
        output enable, cmd, data_rx, done_rx, active_tx, done_tx, result_checksum,
        input  tx_byte, enable_tx, data, crc, status, retry_count, busy, dbg_state
    );
endinterface

// File: rtl/bus_request_ctrl.sv
// Sends a command byte over UART TX, collects an NBYTES payload plus CRC from RX,
// and retransmits on RX inactivity timeout or checksum failure.
module bus_request_ctrl #(
    parameter int NBYTES         = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 2,
    parameter int TMR_W          = 16
) (
    input  logic               clock,
    input  logic               reset,
    bus_request_ctrl_if.slave  bus
);
    localparam int DW    = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NBYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    localparam logic [2:0] ST_WAIT_TX = 3'd0;
    localparam logic [2:0] ST_WAIT_RX = 3'd1;
    localparam logic [2:0] ST_OK      = 3'd2;
    localparam logic [2:0] ST_CRC     = 3'd3;
    localparam logic [2:0] ST_TMO     = 3'd4;

    typedef enum logic [2:0] {
        IDLE, WAIT_TX, START, WAIT_DONE, RX_DATA, RX_CRC, CHECK, FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [DW-1:0]    data_q, data_d;
    logic [7:0]       crc_q, crc_d;
    logic [2:0]       status_q, status_d;
    logic [1:0]       retry_q, retry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             tmo_q, tmo_d;
    logic [DW-1:0]    shifted;

    // First received byte ends up in the MSBs.
    if (NBYTES == 1) begin : g_one
        assign shifted = bus.data_rx;
    end else begin : g_many
        assign shifted = {data_q[DW-9:0], bus.data_rx};
    end

    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        data_d    = data_q;
        crc_d     = crc_q;
        status_d  = status_q;
        retry_d   = retry_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        tmo_d     = tmo_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    tx_byte_d = bus.cmd;
                    retry_d   = 2'd0;
                    status_d  = ST_WAIT_TX;
                    state_d   = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (!(bus.active_tx || bus.done_tx)) state_d = START;
            end
            START: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.done_tx) begin
                    idx_d    = '0;
                    timer_d  = '0;
                    status_d = ST_WAIT_RX;
                    state_d  = RX_DATA;
                end
            end
            RX_DATA, RX_CRC: begin
                // A new request abandons the frame and beats a simultaneous RX byte.
                if (bus.enable) begin
                    tx_byte_d = bus.cmd;
                    retry_d   = 2'd0;
                    idx_d     = '0;
                    timer_d   = '0;
                    status_d  = ST_WAIT_TX;
                    state_d   = WAIT_TX;
                end else if (bus.done_rx) begin
                    timer_d = '0;
                    if (state_q == RX_CRC) begin
                        crc_d   = bus.data_rx;
                        state_d = CHECK;
                    end else begin
                        data_d = shifted;
                        idx_d  = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) state_d = RX_CRC;
                    end
                end else if (timer_q == TMR_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = FAIL;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            CHECK: begin
                if (bus.result_checksum) begin
                    status_d = ST_OK;
                    state_d  = IDLE;
                end else begin
                    tmo_d   = 1'b0;
                    state_d = FAIL;
                end
            end
            FAIL: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d  = retry_q + 2'd1;
                    status_d = ST_WAIT_TX;
                    state_d  = WAIT_TX;
                end else begin
                    status_d = tmo_q ? ST_TMO : ST_CRC;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_byte_q <= 8'd0;
            data_q    <= '0;
            crc_q     <= 8'd0;
            status_q  <= ST_OK;
            retry_q   <= 2'd0;
            idx_q     <= '0;
            timer_q   <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_byte_q <= tx_byte_d;
            data_q    <= data_d;
            crc_q     <= crc_d;
            status_q  <= status_d;
            retry_q   <= retry_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.tx_byte     = tx_byte_q;
    assign bus.enable_tx   = (state_q == START);
    assign bus.data        = data_q;
    assign bus.crc         = crc_q;
    assign bus.status      = status_q;
    assign bus.retry_count = retry_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_bus_request_ctrl.sv
// Directed scoreboard bench for bus_request_ctrl: stimulus pushes expected TX pulses and
// frame completions into queues; a forked monitor pops and compares on each DUT event.
module tb_bus_request_ctrl;
    localparam int NB = 2;
    localparam logic [2:0] S_RX_DATA = 3'd4;
    localparam logic [2:0] S_RX_CRC  = 3'd5;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bus_request_ctrl_if #(.NBYTES(NB)) bus ();

    bus_request_ctrl #(
        .NBYTES(NB), .TIMEOUT_CYCLES(16), .MAX_RETRY(1), .TMR_W(16)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [12:0] tx_q[$];   // {tx_byte, retry_count, status} at each enable_tx pulse
    logic [28:0] exp_q[$];  // {status, retry_count, data, crc} when busy falls

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] tx_exp(input logic [7:0] b, input logic [1:0] r);
        return {b, r, 3'd0};
    endfunction

    function automatic logic [28:0] fr_exp(input logic [2:0] st, input logic [1:0] r,
                                           input logic [15:0] d, input logic [7:0] c);
        return {st, r, d, c};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_enable(input logic [7:0] c);
        tick();
        bus.enable = 1'b1;
        bus.cmd    = c;
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic pulse_done_tx();
        tick();
        bus.done_tx = 1'b1;
        tick();
        bus.done_tx = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        tick();
        bus.done_rx = 1'b1;
        bus.data_rx = b;
        tick();
        bus.done_rx = 1'b0;
    endtask

    task automatic wait_tx_pulse(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (bus.enable_tx) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_tx_pulse: no enable_tx within %0d cycles", bound);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (!bus.busy) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy still high after %0d cycles", bound);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_byte"}, bus.tx_byte, 8'd0);
        check({tag, "_enable_tx"}, bus.enable_tx, 1'b0);
        check({tag, "_data"}, bus.data, 16'd0);
        check({tag, "_crc"}, bus.crc, 8'd0);
        check({tag, "_status"}, bus.status, 3'd2);
        check({tag, "_retry"}, bus.retry_count, 2'd0);
        check({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        int cnt;
        reset               = 1'b1;
        bus.enable          = 1'b0;
        bus.cmd             = 8'd0;
        bus.data_rx         = 8'd0;
        bus.done_rx         = 1'b0;
        bus.active_tx       = 1'b0;
        bus.done_tx         = 1'b0;
        bus.result_checksum = 1'b1;

        fork
            begin : monitor
                logic busy_prev;
                logic [12:0] te;
                logic [28:0] fe;
                busy_prev = 1'b0;
                forever begin
                    @(negedge clock);
                    if (bus.enable_tx) begin
                        if (tx_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL tx_unexpected: tx_byte %0h retry %0d", bus.tx_byte, bus.retry_count);
                        end else begin
                            te = tx_q.pop_front();
                            check("tx_pulse", {bus.tx_byte, bus.retry_count, bus.status}, te);
                        end
                    end
                    if (busy_prev && !bus.busy) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame_unexpected: status %0d data %0h", bus.status, bus.data);
                        end else begin
                            fe = exp_q.pop_front();
                            check("frame", {bus.status, bus.retry_count, bus.data, bus.crc}, fe);
                        end
                    end
                    busy_prev = bus.busy;
                end
            end
            begin : watchdog
                #2000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Nominal transaction
        tx_q.push_back(tx_exp(8'hA5, 2'd0));
        exp_q.push_back(fr_exp(3'd2, 2'd0, 16'h1234, 8'h5C));
        pulse_enable(8'hA5);
        wait_tx_pulse(20);
        pulse_done_tx();
        rx_byte(8'h12);
        rx_byte(8'h34);
        rx_byte(8'h5C);
        wait_idle(50);

        // TX back-pressure
        tx_q.push_back(tx_exp(8'hA5, 2'd0));
        exp_q.push_back(fr_exp(3'd2, 2'd0, 16'h1234, 8'h5C));
        tick();
        bus.active_tx = 1'b1;
        pulse_enable(8'hA5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_no_tx", bus.enable_tx, 1'b0);
            check("bp_status", bus.status, 3'd0);
        end
        tick();
        bus.active_tx = 1'b0;
        @(negedge clock);
        check("bp_hold", bus.enable_tx, 1'b0);
        @(negedge clock);
        check("bp_release", bus.enable_tx, 1'b1);
        pulse_done_tx();
        rx_byte(8'h12);
        rx_byte(8'h34);
        rx_byte(8'h5C);
        wait_idle(50);

        // Timeout with one retry, then final timeout
        tx_q.push_back(tx_exp(8'hA5, 2'd0));
        tx_q.push_back(tx_exp(8'hA5, 2'd1));
        exp_q.push_back(fr_exp(3'd4, 2'd1, 16'h1234, 8'h5C));
        pulse_enable(8'hA5);
        wait_tx_pulse(20);
        pulse_done_tx();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.dbg_state == S_RX_DATA) cnt++;
            else break;
        end
        check("tmo_cycles", cnt, 16);
        wait_tx_pulse(20);
        pulse_done_tx();
        wait_idle(60);

        // CRC error then recovery on retry
        bus.result_checksum = 1'b0;
        tx_q.push_back(tx_exp(8'hA5, 2'd0));
        tx_q.push_back(tx_exp(8'hA5, 2'd1));
        exp_q.push_back(fr_exp(3'd2, 2'd1, 16'h1234, 8'h5C));
        pulse_enable(8'hA5);
        wait_tx_pulse(20);
        pulse_done_tx();
        rx_byte(8'h12);
        rx_byte(8'h34);
        rx_byte(8'h00);
        wait_tx_pulse(20);
        bus.result_checksum = 1'b1;
        pulse_done_tx();
        rx_byte(8'h12);
        rx_byte(8'h34);
        rx_byte(8'h5C);
        wait_idle(50);

        // done_rx on the 16th idle cycle, then restart mid-frame
        tx_q.push_back(tx_exp(8'h5A, 2'd0));
        pulse_enable(8'h5A);
        wait_tx_pulse(20);
        pulse_done_tx();
        repeat (15) @(posedge clock);
        #1;
        bus.done_rx = 1'b1;
        bus.data_rx = 8'h66;
        tick();
        bus.done_rx = 1'b0;
        @(negedge clock);
        check("bnd_state", bus.dbg_state, S_RX_DATA);
        check("bnd_retry", bus.retry_count, 2'd0);
        tx_q.push_back(tx_exp(8'h3C, 2'd0));
        exp_q.push_back(fr_exp(3'd2, 2'd0, 16'hABCD, 8'hEF));
        tick();
        bus.enable  = 1'b1;
        bus.cmd     = 8'h3C;
        bus.done_rx = 1'b1;
        bus.data_rx = 8'h77;
        tick();
        bus.enable  = 1'b0;
        bus.done_rx = 1'b0;
        wait_tx_pulse(20);
        pulse_done_tx();
        rx_byte(8'hAB);
        rx_byte(8'hCD);
        rx_byte(8'hEF);
        wait_idle(50);

        // Asynchronous reset during RX_CRC, then a clean transaction
        tx_q.push_back(tx_exp(8'h11, 2'd0));
        pulse_enable(8'h11);
        wait_tx_pulse(20);
        pulse_done_tx();
        rx_byte(8'h21);
        rx_byte(8'h43);
        check("rst_pre_state", bus.dbg_state, S_RX_CRC);
        exp_q.push_back(fr_exp(3'd2, 2'd0, 16'h0000, 8'h00));
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clock);
        tick();
        reset = 1'b0;
        tx_q.push_back(tx_exp(8'h99, 2'd0));
        exp_q.push_back(fr_exp(3'd2, 2'd0, 16'hBEEF, 8'h01));
        pulse_enable(8'h99);
        wait_tx_pulse(20);
        pulse_done_tx();
        rx_byte(8'hBE);
        rx_byte(8'hEF);
        rx_byte(8'h01);
        wait_idle(50);

        repeat (4) tick();
        check("tx_q_left", tx_q.size(), 0);
        check("exp_q_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_request_ctrl.md
Name: bus_request_ctrl

Overview:
- Parametrised bus transaction controller: on a software request, transmits a command byte through the UART TX path, then collects an NBYTES payload plus one CRC byte from the RX path.
- Validates the frame against the external checksum unit.
- Adds two things the single-byte controller lacks: an RX inactivity timeout, and automatic retransmission on timeout or CRC error.
- Sits between the software-facing register interface and the uart_tx / uart_rx / checksum blocks.

Parameters:
- NBYTES, 2, payload bytes per response frame (≥1).
- TIMEOUT_CYCLES, 50000, clock cycles allowed between RX bytes and before the first RX byte (≥2).
- MAX_RETRY, 2, retransmissions allowed after the first attempt (0 disables retry).
- TMR_W, 16, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  one-cycle request strobe from software.
- cmd  in  8  command byte; sampled when enable is accepted.
- data_rx  in  8  byte from UART RX; valid while done_rx=1.
- done_rx  in  1  one-cycle RX byte-complete strobe.
- active_tx  in  1  TX shifter busy.
- done_tx  in  1  TX byte-complete flag.
- result_checksum  in  1  checksum unit verdict on data/crc outputs (1 = match).
- tx_byte  out  8  byte presented to UART TX.
- enable_tx  out  1  one-cycle TX start pulse.
- data  out  8*NBYTES  received payload; first received byte in the MSBs.
- crc  out  8  received CRC byte.
- status  out  3  0 = waiting TX, 1 = waiting RX, 2 = OK, 3 = CRC error, 4 = timeout.
- retry_count  out  2  retransmissions used by the current request.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
Reset values:
- data=0, crc=0, tx_byte=0, enable_tx=0, status=2, retry_count=0, busy=0.
- Internal: state=IDLE, byte index=0, timer=0.
- Reset mid-transaction aborts immediately; no partial outputs are retained.

State machine:
- IDLE: on enable, latch cmd into tx_byte, clear retry_count → WAIT_TX.
- WAIT_TX: status=0. Stay while active_tx|done_tx, else → START.
- START: enable_tx=1 for exactly this one cycle → WAIT_DONE.
- WAIT_DONE: enable_tx=0. On done_tx → RX_DATA with byte index=0, timer=0. No timeout in this state.
- RX_DATA: status=1.
  - On done_rx: shift data_rx into the data shift register (MSB-first), timer=0, index+1.
  - When index reaches NBYTES → RX_CRC.
- RX_CRC: on done_rx, crc<=data_rx, timer=0 → CHECK.
- CHECK: sample result_checksum, one cycle after data/crc are final.
  - 1 → status=2, IDLE.
  - 0 → FAIL with cause CRC.
- FAIL:
  - If retry_count < MAX_RETRY: retry_count+1, → WAIT_TX, resending the same tx_byte. data/crc hold their last values.
  - Else: status=3 (CRC cause) or 4 (timeout cause), → IDLE.

Timeout:
- In RX_DATA/RX_CRC, timer increments on every cycle without done_rx.
- When timer reaches TIMEOUT_CYCLES-1 without done_rx → FAIL with cause timeout.
- done_rx on that same cycle wins: the byte is accepted and no timeout occurs.

Restart rules:
- enable in RX_DATA/RX_CRC: abandon the frame, latch the new cmd, clear retry_count, index and timer → WAIT_TX. enable has priority over a simultaneous done_rx.
- enable in WAIT_TX/START/WAIT_DONE/CHECK/FAIL: ignored.

Other rules:
- done_rx outside RX_DATA/RX_CRC is ignored.
- status holds its value except where an assignment is stated above; status=2/3/4 persists in IDLE until the next request.
- busy is combinational from state.

Test Plan:
Bench parameters: NBYTES=2, TIMEOUT_CYCLES=16, MAX_RETRY=1.
- Nominal: reset, enable with cmd=0xA5 → one enable_tx pulse with tx_byte=0xA5. Send done_tx, then RX 0x12, 0x34, CRC 0x5C with result_checksum=1 → data=0x1234, crc=0x5C, status=2, retry_count=0, busy=0.
- TX back-pressure: hold active_tx=1 for 10 cycles after enable → status=0 and no enable_tx pulse until the first cycle after active_tx=0 and done_tx=0.
- Timeout with retry: after done_tx send no RX bytes → timeout at cycle 16, second enable_tx pulse with tx_byte=0xA5 and retry_count=1. Still no RX → status=4, IDLE.
- CRC retry recovery: first frame 0x12, 0x34, 0x00 with result_checksum=0 → resend, retry_count=1. Second frame with result_checksum=1 → status=2, data=0x1234.
- Boundary: done_rx arrives on the 16th idle cycle → byte accepted, no retry. enable pulsed together with done_rx mid-frame, cmd=0x3C → restart, tx_byte=0x3C, retry_count=0.
- Async reset asserted during RX_CRC → all outputs return to reset values that cycle; next enable runs a clean transaction.
